// File: rtl/csk_symbol_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : csk_symbol_packer_if
// Purpose  : Byte-stream valid/ready bundle that feeds the CSK symbol packer.
// Revision : 1.0 - initial release
// ============================================================================
interface csk_symbol_packer_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface
`default_nettype wire

// File: rtl/csk_symbol_packer.sv
`default_nettype none
// ============================================================================
// Module   : csk_symbol_packer
// Purpose  : Repacks a byte stream LSB-first into BPS-bit CSK symbols, one per
//            SYMBOL_PERIOD clocks. Optional CSK_PACKER_FLUSH_EN adds a flush input.
// Revision : 1.0 - initial release
// ============================================================================
module csk_symbol_packer #(
    parameter int NUMBER_OF_AXIS   = 3,
    parameter int NUMBER_OF_LEVELS = 4,
    parameter int SYMBOL_PERIOD    = 16
) (
    input  wire                clk,
    input  wire                resetn,
    input  wire                tx_en,
`ifdef CSK_PACKER_FLUSH_EN
    input  wire                flush,
`endif
    csk_symbol_packer_if.slave byte_if,
    output logic [5:0]         symbol_out,
    output logic               symbol_strobe,
    output logic               underrun,
    output logic [4:0]         bit_count
);

    localparam int BPS  = NUMBER_OF_AXIS * ((NUMBER_OF_LEVELS == 4) ? 2 : 1);
    localparam int TW   = (SYMBOL_PERIOD > 2) ? $clog2(SYMBOL_PERIOD) : 1;

    localparam logic [4:0]    c_bps      = 5'(BPS);
    localparam logic [4:0]    c_byte     = 5'd8;
    localparam logic [TW-1:0] c_tmr_last = TW'(SYMBOL_PERIOD - 1);

    logic [TW-1:0] r_timer;
    logic [15:0]   r_buf;
    logic [4:0]    r_count;
    logic [5:0]    r_symbol;
    logic          r_strobe;
    logic          r_underrun;

    logic          w_tick;
    logic          w_accept;
    logic          w_consume;
    logic          w_flush;
    logic [15:0]   w_buf_shift;
    logic [4:0]    w_count_shift;
    logic [15:0]   w_buf_next;
    logic [4:0]    w_count_next;
    logic [5:0]    w_symbol;

    assign w_tick     = tx_en && (r_timer == c_tmr_last);
    assign w_accept   = byte_if.data_valid && byte_if.data_ready;
    assign w_consume  = w_tick && (r_count >= c_bps);

`ifdef CSK_PACKER_FLUSH_EN
    // A partial symbol is only flushed when nothing complete is available.
    assign w_flush    = w_tick && flush && (r_count != 5'd0) && (r_count < c_bps);
`else
    assign w_flush    = 1'b0;
`endif

    assign byte_if.data_ready = (r_count <= c_byte);

    // Bits above bit_count are always zero, so a flushed partial symbol is
    // naturally zero-padded.
    always_comb begin
        w_symbol              = '0;
        w_symbol[BPS-1:0]     = r_buf[BPS-1:0];

        w_buf_shift   = r_buf;
        w_count_shift = r_count;
        if (w_consume) begin
            w_buf_shift   = r_buf >> BPS;
            w_count_shift = r_count - c_bps;
        end else if (w_flush) begin
            w_buf_shift   = '0;
            w_count_shift = '0;
        end

        // The new byte lands above whatever survives this cycle's shift.
        w_buf_next   = w_buf_shift;
        w_count_next = w_count_shift;
        if (w_accept) begin
            w_buf_next   = w_buf_shift | ({8'h00, byte_if.data_in} << w_count_shift);
            w_count_next = w_count_shift + c_byte;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_timer    <= '0;
            r_buf      <= '0;
            r_count    <= '0;
            r_symbol   <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (!tx_en || (r_timer == c_tmr_last)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            r_buf      <= w_buf_next;
            r_count    <= w_count_next;
            r_strobe   <= w_consume || w_flush;
            r_underrun <= w_tick && !w_consume && !w_flush;

            if (w_consume || w_flush) begin
                r_symbol <= w_symbol;
            end
        end
    end

    assign symbol_out    = r_symbol;
    assign symbol_strobe = r_strobe;
    assign underrun      = r_underrun;
    assign bit_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_csk_symbol_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_csk_symbol_packer
// Purpose  : Directed, self-checking bench for csk_symbol_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csk_symbol_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn;
    logic       tx_en_a;
    logic       tx_en_b;
`ifdef CSK_PACKER_FLUSH_EN
    logic       flush;
`endif
    logic [5:0] sym_a;
    logic [5:0] sym_b;
    logic       stb_a;
    logic       stb_b;
    logic       und_a;
    logic       und_b;
    logic [4:0] cnt_a;
    logic [4:0] cnt_b;

    csk_symbol_packer_if bus_a ();
    csk_symbol_packer_if bus_b ();

    csk_symbol_packer #(
        .NUMBER_OF_AXIS   (3),
        .NUMBER_OF_LEVELS (4),
        .SYMBOL_PERIOD    (4)
    ) u_dut_a (
        .clk           (clk),
        .resetn        (resetn),
        .tx_en         (tx_en_a),
`ifdef CSK_PACKER_FLUSH_EN
        .flush         (flush),
`endif
        .byte_if       (bus_a),
        .symbol_out    (sym_a),
        .symbol_strobe (stb_a),
        .underrun      (und_a),
        .bit_count     (cnt_a)
    );

    csk_symbol_packer #(
        .NUMBER_OF_AXIS   (1),
        .NUMBER_OF_LEVELS (4),
        .SYMBOL_PERIOD    (4)
    ) u_dut_b (
        .clk           (clk),
        .resetn        (resetn),
        .tx_en         (tx_en_b),
`ifdef CSK_PACKER_FLUSH_EN
        .flush         (1'b0),
`endif
        .byte_if       (bus_b),
        .symbol_out    (sym_b),
        .symbol_strobe (stb_b),
        .underrun      (und_b),
        .bit_count     (cnt_b)
    );

    typedef struct {
        logic       tx;
        logic       v;
        logic [7:0] d;
        logic [5:0] sym;
        logic       stb;
        logic       und;
        logic [4:0] cnt;
        logic       rdy;
    } vec_t;

    vec_t tbl [23];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic tx, input logic v, input logic [7:0] d,
                                input logic [5:0] sym, input logic stb, input logic und,
                                input logic [4:0] cnt, input logic rdy);
        vec_t r;
        r.tx = tx; r.v = v; r.d = d; r.sym = sym;
        r.stb = stb; r.und = und; r.cnt = cnt; r.rdy = rdy;
        return r;
    endfunction

    task automatic step_a(input logic tx, input logic v, input logic [7:0] d);
        tx_en_a          = tx;
        bus_a.data_valid = v;
        bus_a.data_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic tx, input logic v, input logic [7:0] d);
        tx_en_b          = tx;
        bus_b.data_valid = v;
        bus_b.data_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tx_en_a = 1'b0; bus_a.data_valid = 1'b0; bus_a.data_in = 8'h00;
        tx_en_b = 1'b0; bus_b.data_valid = 1'b0; bus_b.data_in = 8'h00;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [5:0] exp_b [4];
        exp_b[0] = 6'd0; exp_b[1] = 6'd1; exp_b[2] = 6'd3; exp_b[3] = 6'd2;
`ifdef CSK_PACKER_FLUSH_EN
        flush = 1'b0;
`endif

        // Preload 0xA5, 0x3C with the timer off, then 0xF0 joins once room appears.
        tbl[0]  = mk(0, 1, 8'hA5, 6'h00, 0, 0, 5'd8,  1);
        tbl[1]  = mk(0, 1, 8'h3C, 6'h00, 0, 0, 5'd16, 0);
        tbl[2]  = mk(1, 1, 8'hF0, 6'h00, 0, 0, 5'd16, 0);
        tbl[3]  = mk(1, 1, 8'hF0, 6'h00, 0, 0, 5'd16, 0);
        tbl[4]  = mk(1, 1, 8'hF0, 6'h00, 0, 0, 5'd16, 0);
        tbl[5]  = mk(1, 1, 8'hF0, 6'h25, 1, 0, 5'd10, 0);
        tbl[6]  = mk(1, 1, 8'hF0, 6'h25, 0, 0, 5'd10, 0);
        tbl[7]  = mk(1, 1, 8'hF0, 6'h25, 0, 0, 5'd10, 0);
        tbl[8]  = mk(1, 1, 8'hF0, 6'h25, 0, 0, 5'd10, 0);
        tbl[9]  = mk(1, 1, 8'hF0, 6'h32, 1, 0, 5'd4,  1);
        tbl[10] = mk(1, 1, 8'hF0, 6'h32, 0, 0, 5'd12, 0);
        tbl[11] = mk(1, 0, 8'h00, 6'h32, 0, 0, 5'd12, 0);
        tbl[12] = mk(1, 0, 8'h00, 6'h32, 0, 0, 5'd12, 0);
        tbl[13] = mk(1, 0, 8'h00, 6'h03, 1, 0, 5'd6,  1);
        tbl[14] = mk(1, 0, 8'h00, 6'h03, 0, 0, 5'd6,  1);
        tbl[15] = mk(1, 0, 8'h00, 6'h03, 0, 0, 5'd6,  1);
        tbl[16] = mk(1, 0, 8'h00, 6'h03, 0, 0, 5'd6,  1);
        tbl[17] = mk(1, 0, 8'h00, 6'h3C, 1, 0, 5'd0,  1);
        tbl[18] = mk(1, 0, 8'h00, 6'h3C, 0, 0, 5'd0,  1);
        tbl[19] = mk(1, 0, 8'h00, 6'h3C, 0, 0, 5'd0,  1);
        tbl[20] = mk(1, 0, 8'h00, 6'h3C, 0, 0, 5'd0,  1);
        tbl[21] = mk(1, 0, 8'h00, 6'h3C, 0, 1, 5'd0,  1);
        tbl[22] = mk(1, 0, 8'h00, 6'h3C, 0, 0, 5'd0,  1);

        do_reset();
        chk("reset sym",   32'(sym_a), 32'h0);
        chk("reset stb",   32'(stb_a), 32'h0);
        chk("reset und",   32'(und_a), 32'h0);
        chk("reset cnt",   32'(cnt_a), 32'h0);
        chk("reset ready", 32'(bus_a.data_ready), 32'h1);

        for (int i = 0; i < 23; i++) begin
            step_a(tbl[i].tx, tbl[i].v, tbl[i].d);
            chk($sformatf("row%0d sym", i),   32'(sym_a), 32'(tbl[i].sym));
            chk($sformatf("row%0d stb", i),   32'(stb_a), 32'(tbl[i].stb));
            chk($sformatf("row%0d und", i),   32'(und_a), 32'(tbl[i].und));
            chk($sformatf("row%0d cnt", i),   32'(cnt_a), 32'(tbl[i].cnt));
            chk($sformatf("row%0d ready", i), 32'(bus_a.data_ready), 32'(tbl[i].rdy));
        end

        // Byte accepted on the same edge as a tick with six bits buffered.
        do_reset();
        step_a(0, 1, 8'hA5);
        step_a(0, 1, 8'h3C);
        for (int e = 1; e <= 15; e++) step_a(1, e == 9, 8'hF0);
        chk("same_edge cnt_before", 32'(cnt_a), 32'd6);
        step_a(1, 1, 8'h5A);
        chk("same_edge sym", 32'(sym_a), 32'h3C);
        chk("same_edge stb", 32'(stb_a), 32'h1);
        chk("same_edge cnt", 32'(cnt_a), 32'd8);
        for (int e = 17; e <= 19; e++) step_a(1, 0, 8'h00);
        step_a(1, 0, 8'h00);
        chk("same_edge next sym", 32'(sym_a), 32'h1A);
        chk("same_edge next stb", 32'(stb_a), 32'h1);
        chk("same_edge next cnt", 32'(cnt_a), 32'd2);
        for (int e = 21; e <= 23; e++) step_a(1, 0, 8'h00);
        step_a(1, 0, 8'h00);
        chk("partial und", 32'(und_a), 32'h1);
        chk("partial stb", 32'(stb_a), 32'h0);
        chk("partial sym", 32'(sym_a), 32'h1A);
        chk("partial cnt", 32'(cnt_a), 32'd2);

        // Asynchronous reset with twelve bits buffered.
        do_reset();
        step_a(0, 1, 8'hA5);
        step_a(0, 1, 8'h3C);
        for (int e = 1; e <= 9; e++) step_a(1, e == 9, 8'hF0);
        chk("pre_rst cnt", 32'(cnt_a), 32'd12);
        chk("pre_rst sym", 32'(sym_a), 32'h32);
        bus_a.data_valid = 1'b0;
        resetn = 1'b0;
        #2;
        chk("async_rst cnt",   32'(cnt_a), 32'd0);
        chk("async_rst sym",   32'(sym_a), 32'h0);
        chk("async_rst ready", 32'(bus_a.data_ready), 32'h1);
        chk("async_rst stb",   32'(stb_a), 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step_a(1, 0, 8'h00);
            chk($sformatf("post_rst e%0d stb", e), 32'(stb_a), 32'h0);
            chk($sformatf("post_rst e%0d und", e), 32'(und_a), 32'((e % 4) == 0));
        end

        // Single-axis build: two bits per symbol.
        do_reset();
        step_b(0, 1, 8'hB4);
        for (int e = 1; e <= 16; e++) begin
            step_b(1, 0, 8'h00);
            chk($sformatf("bps2 e%0d upper", e), 32'(sym_b[5:2]), 32'h0);
            if ((e % 4) == 0) begin
                chk($sformatf("bps2 e%0d stb", e), 32'(stb_b), 32'h1);
                chk($sformatf("bps2 e%0d sym", e), 32'(sym_b), 32'(exp_b[e/4 - 1]));
            end
        end
        chk("bps2 final cnt", 32'(cnt_b), 32'd0);

        // Partial symbol handling: flushed in the flush build, held otherwise.
        do_reset();
`ifdef CSK_PACKER_FLUSH_EN
        flush = 1'b1;
`endif
        step_a(0, 1, 8'hFF);
        for (int e = 1; e <= 4; e++) step_a(1, 0, 8'h00);
        chk("tail first sym", 32'(sym_a), 32'h3F);
        chk("tail first stb", 32'(stb_a), 32'h1);
        chk("tail first cnt", 32'(cnt_a), 32'd2);
        for (int e = 5; e <= 8; e++) step_a(1, 0, 8'h00);
`ifdef CSK_PACKER_FLUSH_EN
        chk("flush sym", 32'(sym_a), 32'h03);
        chk("flush stb", 32'(stb_a), 32'h1);
        chk("flush und", 32'(und_a), 32'h0);
        chk("flush cnt", 32'(cnt_a), 32'd0);
`else
        chk("hold sym", 32'(sym_a), 32'h3F);
        chk("hold stb", 32'(stb_a), 32'h0);
        chk("hold und", 32'(und_a), 32'h1);
        chk("hold cnt", 32'(cnt_a), 32'd2);
`endif
        for (int e = 9; e <= 12; e++) step_a(1, 0, 8'h00);
        chk("tail late und", 32'(und_a), 32'h1);
        chk("tail late stb", 32'(stb_a), 32'h0);
`ifdef CSK_PACKER_FLUSH_EN
        chk("tail late cnt", 32'(cnt_a), 32'd0);
`else
        chk("tail late cnt", 32'(cnt_a), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
